// File: rtl/input_setup_if.sv
// input_setup_if: host-side write port and array-side stream port of the
// input_setup activation feeder. clk/reset stay plain ports on the module.
interface input_setup_if #(
  parameter int DATA_WIDTH = 16,
  parameter int COL_W      = 1
);
  logic                  start;
  logic                  wr_en;
  logic                  wr_row;
  logic [COL_W-1:0]      wr_col;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] a_in1;
  logic [DATA_WIDTH-1:0] a_in2;
  logic                  valid;
  logic                  busy;
  logic                  done;
  logic                  wr_drop;

  // Host / testbench side
  modport master (
    output start, wr_en, wr_row, wr_col, wr_data,
    input  a_in1, a_in2, valid, busy, done, wr_drop
  );

  // Feeder side
  modport slave (
    input  start, wr_en, wr_row, wr_col, wr_data,
    output a_in1, a_in2, valid, busy, done, wr_drop
  );
endinterface

// File: rtl/input_setup.sv
// input_setup: holds a 2xK activation matrix and streams it into a 2-row
// systolic array with row 1 skewed one cycle behind row 0, followed by
// FLUSH_CYCLES zero cycles with valid high, then a one-cycle done pulse.
// Optional feature: define INPUT_SETUP_PINGPONG_EN for two matrix banks so
// the next matrix can be loaded while the current one streams.
module input_setup #(
  parameter int DATA_WIDTH   = 16,
  parameter int K            = 2,
  parameter int FLUSH_CYCLES = 4,
  parameter int COL_W        = (K > 1) ? $clog2(K) : 1
) (
  input logic          clk,
  input logic          reset,   // synchronous, active-low
  input_setup_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH, S_DONE} state_e;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] K_LAST  = CNT_W'(K);
  localparam logic [CNT_W-1:0] FL_LAST = CNT_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [COL_W:0]   K_LIM   = (COL_W + 1)'(K);
`ifdef INPUT_SETUP_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [DATA_WIDTH-1:0] mem_q [NB][2][K];

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            fill_bank_q, fill_bank_d;
  logic            stream_bank_q, stream_bank_d;

  logic [DATA_WIDTH-1:0] a_in1_q, a_in1_d, a_in2_q, a_in2_d;
  logic                  valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic                  wr_drop_q, wr_drop_d;

  logic start_acc, col_ok, wr_acc;

  assign start_acc = bus.start && (state_q == S_IDLE);
  assign col_ok    = ({1'b0, bus.wr_col} < K_LIM);
`ifdef INPUT_SETUP_PINGPONG_EN
  assign wr_acc    = bus.wr_en && col_ok && !bus.start;
`else
  assign wr_acc    = bus.wr_en && col_ok && !bus.start && (state_q == S_IDLE);
`endif

  // State, pass counter and bank pointers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      fill_bank_q   <= 1'b0;
      stream_bank_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fill_bank_q   <= fill_bank_d;
      stream_bank_q <= stream_bank_d;
    end
  end

  // Next-state: IDLE -> STREAM (K+1 cycles) -> FLUSH -> DONE -> IDLE
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_bank_d   = fill_bank_q;
    stream_bank_d = stream_bank_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_STREAM;
          cnt_d   = '0;
`ifdef INPUT_SETUP_PINGPONG_EN
          stream_bank_d = fill_bank_q;
          fill_bank_d   = ~fill_bank_q;
`endif
        end
      end
      S_STREAM: begin
        if (cnt_q == K_LAST) begin
          cnt_d   = '0;
          state_d = (FLUSH_CYCLES > 0) ? S_FLUSH : S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == FL_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs for the upcoming cycle, derived from next state so they register in step
  always_comb begin
    a_in1_d   = '0;
    a_in2_d   = '0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    wr_drop_d = bus.wr_en && !wr_acc;
    case (state_d)
      S_STREAM: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (cnt_d < K_LAST)
          a_in1_d = mem_q[stream_bank_d][0][COL_W'(cnt_d)];
        if (cnt_d != '0)
          a_in2_d = mem_q[stream_bank_d][1][COL_W'(cnt_d - CNT_W'(1))];
      end
      S_FLUSH: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_in1_q   <= '0;
      a_in2_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      a_in1_q   <= a_in1_d;
      a_in2_q   <= a_in2_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Activation storage: host writes land in the fill bank
  always_ff @(posedge clk) begin
    // NOTE: the matrix is cleared by reset so a pass after reset streams zeros, not stale data.
    if (!reset) begin
      for (int b = 0; b < NB; b++)
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < K; c++)
            mem_q[b][r][c] <= '0;
    end else if (wr_acc) begin
      mem_q[fill_bank_q][bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end

  assign bus.a_in1   = a_in1_q;
  assign bus.a_in2   = a_in2_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_drop = wr_drop_q;

endmodule

// File: tb/tb_input_setup.sv
// tb_input_setup: scoreboard bench for input_setup. The driver pushes the
// expected stream (computed from a plain matrix model) when it launches a
// pass; a negedge monitor pops and compares whenever valid or done is high.
module tb_input_setup;
  localparam int DW       = 16;
  localparam int K        = 3;
  localparam int FL       = 4;
  localparam int COL_W    = 2;
  localparam int PASS_LEN = K + 1 + FL;
`ifdef INPUT_SETUP_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  input_setup_if #(.DATA_WIDTH(DW), .COL_W(COL_W)) bus ();

  input_setup #(.DATA_WIDTH(DW), .K(K), .FLUSH_CYCLES(FL), .COL_W(COL_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit            is_done;
    logic [DW-1:0] a1;
    logic [DW-1:0] a2;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            vcount   = 0;
  logic [DW-1:0] mdl [2][2][K];
  int            fill_bank = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < K; c++)
          mdl[b][r][c] = '0;
    fill_bank = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_in1"}, bus.a_in1, 0);
    check({tag, "_a_in2"}, bus.a_in2, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_wr_drop"}, bus.wr_drop, 0);
  endtask

  // One write cycle; the bench decides from context whether it should be dropped
  task automatic write(input bit row, input int col, input logic [DW-1:0] data, input bit in_pass);
    bit exp_drop;
    exp_drop    = (col >= K) || (in_pass && !PP);
    bus.wr_en   = 1'b1;
    bus.wr_row  = row;
    bus.wr_col  = COL_W'(col);
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    check("wr_drop", bus.wr_drop, exp_drop);
    if (!exp_drop) mdl[fill_bank][row][col] = data;
  endtask

  // Launch a pass from IDLE; optionally with a same-cycle write that must be dropped
  task automatic launch(input bit with_wr, input bit row, input int col, input logic [DW-1:0] data);
    exp_t e;
    int   sb;
    bus.start   = 1'b1;
    bus.wr_en   = with_wr;
    bus.wr_row  = row;
    bus.wr_col  = COL_W'(col);
    bus.wr_data = data;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    if (with_wr) check("wr_drop_with_start", bus.wr_drop, 1);
    sb = fill_bank;
    for (int t = 0; t <= K; t++) begin
      e.is_done = 1'b0;
      e.a1 = '0;
      e.a2 = '0;
      if (t < K)  e.a1 = mdl[sb][0][t];
      if (t >= 1) e.a2 = mdl[sb][1][t-1];
      exp_q.push_back(e);
    end
    for (int f = 0; f < FL; f++) begin
      e.is_done = 1'b0;
      e.a1 = '0;
      e.a2 = '0;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.a1 = '0;
    e.a2 = '0;
    exp_q.push_back(e);
    if (PP) fill_bank ^= 1;
  endtask

  // Bounded wait for done, then step into IDLE
  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    check("done_seen", bus.done, 1);
    tick();
    check("idle_busy", bus.busy, 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && (bus.valid || bus.done)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: valid=%0b done=%0b with nothing expected (t=%0t)",
                 bus.valid, bus.done, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_flag", bus.done, mon_e.is_done);
        check("valid_flag", bus.valid, !mon_e.is_done);
        check("busy_flag", bus.busy, !mon_e.is_done);
        if (!mon_e.is_done) begin
          check("a_in1", bus.a_in1, mon_e.a1);
          check("a_in2", bus.a_in2, mon_e.a2);
          vcount++;
        end else begin
          check("pass_len", vcount, PASS_LEN);
          vcount = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_row  = 1'b0;
    bus.wr_col  = '0;
    bus.wr_data = '0;
    reset       = 1'b0;
    clear_model();
    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Basic pass; writes during STREAM are dropped (single bank) or fill the other bank
    write(0, 0, 16'd11, 0);
    write(0, 1, 16'd12, 0);
    write(0, 2, 16'd13, 0);
    write(1, 0, 16'd21, 0);
    write(1, 1, 16'd22, 0);
    write(1, 2, 16'd23, 0);
    launch(0, 0, 0, '0);
    write(0, 0, 16'd5, 1);
    write(0, 1, 16'd6, 1);
    write(0, 2, 16'd9, 1);
    write(1, 0, 16'd7, 1);
    write(1, 1, 16'd8, 1);
    write(1, 2, 16'd10, 1);
    wait_done();

    // Second pass with start re-asserted mid-STREAM (must be ignored)
    launch(0, 0, 0, '0);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done();

    // Out-of-range column, then start with a same-cycle write
    write(0, 3, 16'hBEEF, 0);
    write(1, 3, 16'h1111, 0);
    launch(1, 0, 0, 16'h1234);
    wait_done();

    // Randomized passes
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 5; i++)
        write(1'($urandom_range(0, 1)), int'($urandom_range(0, K)), DW'($urandom), 0);
      launch(0, 0, 0, '0);
      for (int i = 0; i < 2; i++)
        write(1'($urandom_range(0, 1)), int'($urandom_range(0, K)), DW'($urandom), 1);
      wait_done();
    end

    // Reset low during STREAM cycle t=1
    launch(0, 0, 0, '0);
    tick();
    reset = 1'b0;
    tick();
    exp_q.delete();
    vcount = 0;
    clear_model();
    check_all_zero("midreset");
    reset = 1'b1;
    tick();
    check("midreset_no_done", bus.done, 0);
    launch(0, 0, 0, '0);
    wait_done();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/input_setup.md
# input_setup

Activation feeder for the 2-row systolic array. It holds a 2×K activation matrix written by the host side and, on `start`, streams it into the array's `a_in1`/`a_in2`/`valid` inputs with the diagonal skew the array requires. Row 1 is delayed one cycle behind row 0, followed by zero flush cycles so partial sums drain into the accumulators. It sits directly upstream of `top_level_module` and replaces hand-skewed stimulus.

## Interface
Parameters:
- `DATA_WIDTH`, 16, activation width; matches array `a_in*`.
- `K`, 2, row length (columns of A); legal 1..8.
- `FLUSH_CYCLES`, 4, zero cycles with `valid=1` after the last activation; legal 0..15.
- `COL_W`, `$clog2(K)` (min 1), width of `wr_col`.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low: `reset==0` at a rising edge resets the block.
- `start`  in  1  begin streaming; sampled only in IDLE.
- `wr_en`  in  1  activation write strobe.
- `wr_row`  in  1  row index (0 → `a_in1` lane, 1 → `a_in2` lane).
- `wr_col`  in  COL_W  column index.
- `wr_data`  in  DATA_WIDTH  activation value.
- `a_in1`  out  DATA_WIDTH  row-0 lane to array.
- `a_in2`  out  DATA_WIDTH  row-1 lane to array.
- `valid`  out  1  array enable.
- `busy`  out  1  high in STREAM and FLUSH.
- `done`  out  1  one-cycle pulse at end of a pass.
- `wr_drop`  out  1  one-cycle pulse: the previous cycle's write was rejected.

## Operation
- Storage: 2×K register array A[r][c]; cleared to 0 by reset.
- Write accepted when `wr_en=1` and `wr_col<K`, the state is IDLE (see Configuration), and `start=0`. Otherwise the write is dropped and `wr_drop=1` the next cycle.
- States: IDLE → STREAM (on `start`) → FLUSH (after K+1 stream cycles) → DONE (after FLUSH_CYCLES; skipped straight to DONE if 0) → IDLE.
- STREAM cycle t, t = 0..K:
  - `a_in1` = A[0][t] if t<K, else 0.
  - `a_in2` = A[1][t-1] if t≥1, else 0.
  - `valid=1`.
- FLUSH: `a_in1=a_in2=0`, `valid=1`.
- DONE: `valid=0`, `done=1` for exactly one cycle, `busy=0`.
- IDLE: `a_in1=a_in2=0`, `valid=0`, `busy=0`.
- `start` outside IDLE is ignored with no queueing. `start` in DONE is also ignored.
- No arithmetic. Values pass through unmodified at DATA_WIDTH.

## Timing
- All outputs are registered.
- Reset values: `a_in1=0`, `a_in2=0`, `valid=0`, `busy=0`, `done=0`, `wr_drop=0`; state IDLE.
- Latency: `start` high at edge E → first stream outputs visible after E (cycle E+1).
- Pass length: `valid` is high for K+1+FLUSH_CYCLES consecutive cycles. `done` follows in the next cycle. A new `start` is accepted at the earliest on the edge ending the `done` cycle's successor (IDLE).
- Reset low mid-pass: state IDLE and all outputs 0 after that edge; buffer cleared; no `done`.
- A write in the same cycle as a rejected/accepted `start` is dropped, so stream contents never change mid-launch.

## Configuration
- `INPUT_SETUP_PINGPONG_EN` defined:
  - Two banks of A plus a `fill_bank` register (reset 0).
  - Writes always target `fill_bank` and are accepted in any state (subject to `wr_col<K` and `start=0`).
  - An accepted `start` latches `stream_bank<=fill_bank` and toggles `fill_bank`.
  - This lets the next matrix load while the current one streams.
- Undefined: single bank; writes in any state other than IDLE are dropped with `wr_drop`.

## Test plan
- **Basic 2×2 pass.** K=2, FLUSH_CYCLES=4; write A0=[11,12], A1=[21,22]; `start` → (`a_in1`,`a_in2`) = (11,0),(12,21),(0,22), then 4×(0,0), all with `valid=1`; then `done=1` for 1 cycle with `valid=0`.
- **Downstream check.** Same stream into `top_level_module` with weights loaded via LOAD_ADDR/LOAD_WEIGHT → unified buffer equals the bench's golden A×W.
- **Rejected writes.**
  - Write with `wr_col=2` (K=2) → `wr_drop` pulses and A is unchanged.
  - Write during STREAM without the macro → dropped and `wr_drop` pulses.
  - `wr_en` together with `start` → dropped.
- **Start while busy.** `start` re-asserted mid-STREAM → no restart; `valid` high for exactly 7 cycles.
- **Reset mid-pass.** `reset=0` during cycle t=1 of STREAM → next cycle all outputs 0, no `done`; a subsequent `start` streams all zeros.
- **Ping-pong (macro on).**
  - Pass 1 streams [11,12]/[21,22] while [5,6]/[7,8] are written.
  - Pass 2 streams (5,0),(6,7),(0,8).
  - No `wr_drop` in either pass.
